// File: rtl/count99_seq_ctrl.sv
// rtl/count99_seq_ctrl.sv - step sequencer for the 00-99 BCD counter (option: COUNT99_SEQ_CTRL_PINGPONG_EN)
// Paces counter steps with a prescaler, runs to a latched BCD target, supports hold/resume.
module count99_seq_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int PW       = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       start,
    input  logic       dir_sel,
    input  logic       hold,
    input  logic [7:0] target,
    input  logic [7:0] Count,
    output logic       UpOrDown,
    output logic       pause,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = {{(PW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    tgt_q, tgt_d;
    logic          ud_q, ud_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic match;
    logic tgt_ok;

    assign match  = (Count == tgt_q);
    assign tgt_ok = (target[7:4] <= 4'd9) && (target[3:0] <= 4'd9);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tgt_d   = tgt_q;
        ud_d    = ud_q;
        err_d   = err_q;
        done_d  = 1'b0;
        pause   = 1'b1;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && tgt_ok) begin
                    tgt_d   = target;
                    ud_d    = dir_sel;
                    presc_d = '0;
                    err_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    if (start) begin
                        err_d = 1'b1;
                    end
`ifdef COUNT99_SEQ_CTRL_PINGPONG_EN
                    // Bounce: reverse direction and run to the far end of the range.
                    if (state_q == S_DONE) begin
                        ud_d    = ~ud_q;
                        tgt_d   = ud_q ? 8'h00 : 8'h99;
                        presc_d = '0;
                        state_d = S_RUN;
                    end
`endif
                end
            end
            S_RUN: begin
                // A match suppresses the step so the counter never passes the target.
                if (match) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (presc_q == PRESC_LAST) begin
                        pause   = 1'b0;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + PRESC_ONE;
                    end
                    if (hold) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (hold) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            tgt_q   <= 8'h00;
            ud_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tgt_q   <= tgt_d;
            ud_q    <= ud_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign UpOrDown = ud_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign state    = state_q;

endmodule

// File: tb/tb_count99_seq_ctrl.sv
// tb/tb_count99_seq_ctrl.sv - directed vector and sequence bench for count99_seq_ctrl
module tb_count99_seq_ctrl;

    logic       Clk, Rst, start, dir_sel, hold;
    logic [7:0] target, Count;
    logic       UpOrDown, pause, busy, done, err;
    logic [1:0] state;

    logic       use_model, load;
    logic [7:0] vec_cnt, model_cnt, load_val;

    int checks = 0;
    int errors = 0;

    count99_seq_ctrl #(.TICK_DIV(4), .PW(16)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .dir_sel(dir_sel), .hold(hold),
        .target(target), .Count(Count), .UpOrDown(UpOrDown), .pause(pause),
        .busy(busy), .done(done), .err(err), .state(state)
    );

    always #5 Clk = ~Clk;

    assign Count = use_model ? model_cnt : vec_cnt;

    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up);
        logic [3:0] t, u;
        t = v[7:4];
        u = v[3:0];
        if (up) begin
            if (u == 4'd9) begin u = 4'd0; t = (t == 4'd9) ? 4'd0 : t + 4'd1; end
            else u = u + 4'd1;
        end else begin
            if (u == 4'd0) begin u = 4'd9; t = (t == 4'd0) ? 4'd9 : t - 4'd1; end
            else u = u - 4'd1;
        end
        return {t, u};
    endfunction

    // Behavioural stand-in for the zero00_99_00 counter.
    always @(posedge Clk) begin
        if (load) model_cnt <= load_val;
        else if (!pause) model_cnt <= bcd_step(model_cnt, UpOrDown);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic rst, start, dir, hold;
        logic [7:0] tgt, cnt;
        logic [1:0] st;
        logic busy, done, err, ud, pause;
    } vec_t;

    vec_t tbl[$];

    task automatic do_reset(input logic [7:0] v);
        @(negedge Clk);
        Rst = 1; load = 1; load_val = v; use_model = 1; start = 0; hold = 0;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 0; load = 0;
    endtask

    // Issues a start at k=0 and follows the run until done, recording step cycles.
    task automatic watch(input logic [7:0] tgt, input logic dir, input int hold_on, input int hold_off,
                         output int npulse, output int p[8], output logic [7:0] c[8],
                         output int done_k, output int hold_pulses);
        npulse = 0; done_k = -1; hold_pulses = 0;
        for (int i = 0; i < 8; i++) begin p[i] = -1; c[i] = 8'hxx; end
        target = tgt; dir_sel = dir;
        for (int k = 0; k < 300; k++) begin
            @(negedge Clk);
            start = (k == 0);
            hold  = (k == hold_on) || (k == hold_off);
            if (!pause) begin
                if (npulse < 8) begin p[npulse] = k; c[npulse] = Count; end
                npulse++;
                if (state == 2'd2) hold_pulses++;
            end
            if (done) begin done_k = k; break; end
        end
        start = 0; hold = 0;
    endtask

    int np, dk, hp, quiet;
    int pl[8];
    logic [7:0] cl[8];
    logic [7:0] saved;

    initial begin
        Clk = 0; Rst = 1; start = 0; dir_sel = 0; hold = 0; target = 0;
        use_model = 0; load = 0; load_val = 0; vec_cnt = 0;

        tbl.push_back('{1,0,0,0,8'h00,8'h10, 2'd0,0,0,0,1,1});
        tbl.push_back('{0,0,0,0,8'h00,8'h10, 2'd0,0,0,0,1,1});
        tbl.push_back('{0,1,1,0,8'h3A,8'h10, 2'd0,0,0,1,1,1});
        tbl.push_back('{0,1,0,0,8'hA0,8'h10, 2'd0,0,0,1,1,1});
        tbl.push_back('{0,1,0,0,8'h12,8'h10, 2'd1,1,0,0,0,1});
        tbl.push_back('{0,0,0,0,8'h00,8'h10, 2'd1,1,0,0,0,1});
        tbl.push_back('{0,1,1,0,8'h00,8'h10, 2'd1,1,0,0,0,1});
        tbl.push_back('{0,0,0,0,8'h00,8'h10, 2'd1,1,0,0,0,0});
        tbl.push_back('{0,0,0,1,8'h00,8'h10, 2'd2,1,0,0,0,1});
        tbl.push_back('{0,0,0,0,8'h00,8'h10, 2'd2,1,0,0,0,1});
        tbl.push_back('{0,0,0,1,8'h00,8'h10, 2'd1,1,0,0,0,1});
        tbl.push_back('{0,0,0,0,8'h00,8'h12, 2'd3,0,1,0,0,1});
`ifndef COUNT99_SEQ_CTRL_PINGPONG_EN
        tbl.push_back('{0,0,0,1,8'h00,8'h12, 2'd3,0,0,0,0,1});
        tbl.push_back('{0,1,1,0,8'h12,8'h12, 2'd1,1,0,0,1,1});
        tbl.push_back('{0,0,0,0,8'h00,8'h12, 2'd3,0,1,0,1,1});
        tbl.push_back('{1,1,1,0,8'h00,8'h12, 2'd0,0,0,0,1,1});
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clk);
            Rst = tbl[i].rst; start = tbl[i].start; dir_sel = tbl[i].dir; hold = tbl[i].hold;
            target = tbl[i].tgt; vec_cnt = tbl[i].cnt;
            @(posedge Clk);
            #1;
            chk($sformatf("vec%0d.state", i), {30'd0, state}, {30'd0, tbl[i].st});
            chk($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
            chk($sformatf("vec%0d.done", i), {31'd0, done}, {31'd0, tbl[i].done});
            chk($sformatf("vec%0d.err", i), {31'd0, err}, {31'd0, tbl[i].err});
            chk($sformatf("vec%0d.ud", i), {31'd0, UpOrDown}, {31'd0, tbl[i].ud});
            chk($sformatf("vec%0d.pause", i), {31'd0, pause}, {31'd0, tbl[i].pause});
        end

        // Reset then idle
        do_reset(8'h00);
        for (int i = 0; i < 5; i++) @(negedge Clk);
        chk("idle.pause", {31'd0, pause}, 32'd1);
        chk("idle.state", {30'd0, state}, 32'd0);
        chk("idle.busy", {31'd0, busy}, 32'd0);
        chk("idle.done", {31'd0, done}, 32'd0);
        chk("idle.ud", {31'd0, UpOrDown}, 32'd1);

        // Up run 00 -> 05
        watch(8'h05, 1'b1, -1, -1, np, pl, cl, dk, hp);
        chk("up.npulse", np, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("up.pulse%0d", i), pl[i], 4 + 4 * i);
        chk("up.done_k", dk, 22);
        chk("up.count", {24'd0, Count}, 32'h05);
        chk("up.state", {30'd0, state}, 32'd3);
`ifndef COUNT99_SEQ_CTRL_PINGPONG_EN
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (!pause || done) quiet++;
        end
        chk("up.after_done_quiet", quiet, 0);
        chk("up.count_held", {24'd0, Count}, 32'h05);
`endif

        // Down run through the 00->99 wrap
        do_reset(8'h02);
        watch(8'h97, 1'b0, -1, -1, np, pl, cl, dk, hp);
        chk("down.npulse", np, 5);
        chk("down.step0", {24'd0, cl[0]}, 32'h02);
        chk("down.step1", {24'd0, cl[1]}, 32'h01);
        chk("down.step2", {24'd0, cl[2]}, 32'h00);
        chk("down.step3", {24'd0, cl[3]}, 32'h99);
        chk("down.step4", {24'd0, cl[4]}, 32'h98);
        chk("down.done_k", dk, 22);
        chk("down.count", {24'd0, Count}, 32'h97);
        chk("down.ud", {31'd0, UpOrDown}, 32'd0);

        // Hold for 10 cycles mid-run
        do_reset(8'h00);
        watch(8'h05, 1'b1, 6, 16, np, pl, cl, dk, hp);
        chk("hold.npulse", np, 5);
        chk("hold.pulse0", pl[0], 4);
        chk("hold.pulse1", pl[1], 18);
        chk("hold.pulse4", pl[4], 30);
        chk("hold.steps_in_hold", hp, 0);
        chk("hold.done_k", dk, 32);
        chk("hold.count", {24'd0, Count}, 32'h05);

        // Invalid target, valid start, reset mid-run
        do_reset(8'h40);
        start = 1; target = 8'h3A; dir_sel = 1;
        @(posedge Clk); #1;
        chk("bad.err", {31'd0, err}, 32'd1);
        chk("bad.state", {30'd0, state}, 32'd0);
        @(negedge Clk);
        start = 1; target = 8'h45; dir_sel = 1;
        @(posedge Clk); #1;
        chk("good.err", {31'd0, err}, 32'd0);
        chk("good.state", {30'd0, state}, 32'd1);
        @(negedge Clk);
        start = 0;
        for (int i = 0; i < 4; i++) @(negedge Clk);
        Rst = 1;
        @(posedge Clk); #1;
        chk("abort.state", {30'd0, state}, 32'd0);
        chk("abort.pause", {31'd0, pause}, 32'd1);
        chk("abort.busy", {31'd0, busy}, 32'd0);
        @(negedge Clk);
        Rst = 0;
        for (int i = 0; i < 8; i++) @(negedge Clk);
        chk("abort.count", {24'd0, Count}, 32'h41);

`ifdef COUNT99_SEQ_CTRL_PINGPONG_EN
        begin
            int nd;
            logic [7:0] dc[3];
            logic       du[3];
            nd = 0;
            do_reset(8'h00);
            target = 8'h03; dir_sel = 1;
            for (int k = 0; k < 1000 && nd < 3; k++) begin
                @(negedge Clk);
                start = (k == 0);
                if (done) begin dc[nd] = Count; du[nd] = UpOrDown; nd++; end
            end
            start = 0;
            chk("pp.ndone", nd, 3);
            if (nd == 3) begin
                chk("pp.count0", {24'd0, dc[0]}, 32'h03);
                chk("pp.ud0", {31'd0, du[0]}, 32'd1);
                chk("pp.count1", {24'd0, dc[1]}, 32'h00);
                chk("pp.ud1", {31'd0, du[1]}, 32'd0);
                chk("pp.count2", {24'd0, dc[2]}, 32'h99);
                chk("pp.ud2", {31'd0, du[2]}, 32'd1);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
